clic_preempt: RTL and testbench
===============================

CLIC_PREEMPT -- requirements
Module: clic_preempt

Interface
REQ-001 Parameter NR_INDEX_BITS, default 4, source-index width; the controller has 2**NR_INDEX_BITS sources.
REQ-002 Parameter NR_PRIO_BITS, default 3, priority width.
REQ-003 Parameter STACK_DEPTH, default 4, maximum nesting depth (1..16).
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port cfg_we  in  1  configuration write strobe.
REQ-007 Port cfg_idx  in  NR_INDEX_BITS  source to configure.
REQ-008 Port cfg_prio  in  NR_PRIO_BITS  priority written to cfg_idx.
REQ-009 Port cfg_enable  in  1  enable written to cfg_idx.
REQ-010 Port irq_in  in  2**NR_INDEX_BITS  per-source interrupt lines, rising-edge sensitive.
REQ-011 Port sw_pend_we  in  1  software pend strobe.
REQ-012 Port sw_pend_idx  in  NR_INDEX_BITS  source pended by software.
REQ-013 Port take  in  1  core accepts the presented interrupt.
REQ-014 Port ret  in  1  core returns from the current handler.
REQ-015 Port is_interrupt  out  1  an interrupt is presented.
REQ-016 Port index  out  NR_INDEX_BITS  presented source; 0 when is_interrupt=0.
REQ-017 Port prio  out  NR_PRIO_BITS  priority of the presented source; 0 when is_interrupt=0.
REQ-018 Port threshold  out  NR_PRIO_BITS  priority of the running handler; 0 means thread mode.
REQ-019 Port level  out  $clog2(STACK_DEPTH+1)  current nesting depth.

Function
REQ-020 The block shall hold registered per-source state: prio, enable, pending, and irq_prev (the previous irq_in sample).
REQ-021 The block shall write prio and enable of cfg_idx from cfg_prio/cfg_enable on an edge with cfg_we=1; the write shall not alter pending.
REQ-022 The block shall set pending[i] on an edge where irq_in[i]=1 and irq_prev[i]=0, or where sw_pend_we=1 and sw_pend_idx=i.
REQ-023 Contenders shall be the sources with pending & enable & (prio > threshold) & (i != 2**NR_INDEX_BITS-1); the all-ones index is reserved and shall never be presented.
REQ-024 The winner shall be the contender with the highest prio; ties shall go to the highest index.
REQ-025 is_interrupt, index, and prio shall be combinational from registered state: a pend edge at edge k yields is_interrupt=1 in the cycle after edge k (one-cycle latency).
REQ-026 is_interrupt shall be 0 when level == STACK_DEPTH (stack full), regardless of contenders.
REQ-027 On an edge with take=1 and is_interrupt=1, the block shall clear pending[index], push threshold onto the stack, set threshold to prio, and increment level.
REQ-028 take=1 with is_interrupt=0 shall be ignored.
REQ-029 If pending[index] is cleared by take and set by a new event on the same edge, set shall win.
REQ-030 On an edge with ret=1, take=0 and level>0, the block shall pop the stack into threshold and decrement level.
REQ-031 ret with level=0 shall be ignored; threshold shall remain 0.
REQ-032 When take and ret are both 1, take shall be processed and ret ignored.
REQ-033 Reconfiguring the running source's prio shall not change threshold; the new prio applies only to later arbitration.
REQ-034 In simulation only, an assertion shall fire on ret with level=0 or take with is_interrupt=0.

Reset
REQ-035 With reset=1 at an edge, the block shall clear every prio, enable, pending, irq_prev, and stack entry, and set threshold=0 and level=0.
REQ-036 Reset shall take priority over every concurrent cfg, pend, take, and ret, including mid-handler (level>0).
REQ-037 In the cycle after reset, is_interrupt=0, index=0, prio=0, threshold=0, and level=0.

Verification
REQ-038 Single source: cfg src3 prio=2 en=1, irq_in[3] rises -> next cycle is_interrupt=1, index=3, prio=2; take -> is_interrupt=0, threshold=2, level=1; ret -> threshold=0, level=0.
REQ-039 Tie and reserved index: src5 and src9 at prio=4, pended the same cycle -> index=9; src15 at prio=7 pended -> never presented.
REQ-040 Preemption: take src2 (prio 3); pend src7 (prio 3) -> not presented; pend src1 (prio 5) -> presented and taken, level=2, threshold=5; ret -> threshold=3; ret -> src7 presented.
REQ-041 Stack full (STACK_DEPTH=2): nest prio 1 then 2; pend prio 6 -> is_interrupt stays 0 until ret, then index of the prio-6 source.
REQ-042 Edge cases: take and a new irq rise on the same source at the same edge -> pending remains 1; ret at level=0 -> no change; reset during level=3 -> all outputs 0 next cycle.
REQ-043 Held level: irq_in[4] held high across 10 cycles -> only one pend event is generated.

Source files
------------

// File: rtl/clic_preempt.sv
// ---------------------------------------------------------------------------
// clic_preempt
//
// Purpose:
//   Small core-local interrupt controller with priority-based preemption.
//   Every source has a configurable priority and enable bit, plus a pending
//   bit. A pending bit is set by a rising edge on the source's irq line or by
//   a software pend strobe. The highest-priority enabled pending source whose
//   priority is strictly above the running handler's priority is presented
//   to the core. When the core takes it, the old threshold is pushed on a
//   small nesting stack. A return pops the stack back into the threshold.
//   Source index 2**NR_INDEX_BITS-1 is reserved and is never presented.
//
// Ports:
//   clk           single clock, all state changes on the rising edge
//   reset         synchronous, active-high reset
//   cfg_we        configuration write strobe
//   cfg_idx       source being configured
//   cfg_prio      priority written to cfg_idx
//   cfg_enable    enable written to cfg_idx
//   irq_in        per-source interrupt lines (rising-edge sensitive)
//   sw_pend_we    software pend strobe
//   sw_pend_idx   source pended by software
//   take          core accepts the presented interrupt
//   ret           core returns from the current handler
//   is_interrupt  an interrupt is presented
//   index         presented source (0 when nothing is presented)
//   prio          priority of the presented source (0 when nothing presented)
//   threshold     priority of the running handler, 0 means thread mode
//   level         current nesting depth
// ---------------------------------------------------------------------------
module clic_preempt #(
    parameter int NR_INDEX_BITS = 4,
    parameter int NR_PRIO_BITS  = 3,
    parameter int STACK_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_we,
    input  logic [NR_INDEX_BITS-1:0]         cfg_idx,
    input  logic [NR_PRIO_BITS-1:0]          cfg_prio,
    input  logic                             cfg_enable,
    input  logic [(2**NR_INDEX_BITS)-1:0]    irq_in,
    input  logic                             sw_pend_we,
    input  logic [NR_INDEX_BITS-1:0]         sw_pend_idx,
    input  logic                             take,
    input  logic                             ret,
    output logic                             is_interrupt,
    output logic [NR_INDEX_BITS-1:0]         index,
    output logic [NR_PRIO_BITS-1:0]          prio,
    output logic [NR_PRIO_BITS-1:0]          threshold,
    output logic [$clog2(STACK_DEPTH+1)-1:0] level
);

    localparam int NrSrc  = 2**NR_INDEX_BITS;
    localparam int LevelW = $clog2(STACK_DEPTH+1);

    // Per-source state
    logic [NR_PRIO_BITS-1:0] prio_q [NrSrc];
    logic [NR_PRIO_BITS-1:0] prio_d [NrSrc];
    logic [NrSrc-1:0]        enable_q, enable_d;
    logic [NrSrc-1:0]        pending_q, pending_d;
    logic [NrSrc-1:0]        irqPrev_q, irqPrev_d;

    // Nesting state; stack entry 0 is always the most recently pushed one
    logic [NR_PRIO_BITS-1:0] stack_q [STACK_DEPTH];
    logic [NR_PRIO_BITS-1:0] stack_d [STACK_DEPTH];
    logic [NR_PRIO_BITS-1:0] threshold_q, threshold_d;
    logic [LevelW-1:0]       level_q, level_d;

    // Arbitration results
    logic                     bestFound;
    logic [NR_INDEX_BITS-1:0] bestIdx;
    logic [NR_PRIO_BITS-1:0]  bestPrio;
    logic                     stackFull;

    // Control decisions for this edge
    logic                     accept;
    logic                     popOk;
    logic [NrSrc-1:0]         pendEvent;
    logic [NrSrc-1:0]         swMask;

    // Arbitration: scan upward and use >= so an equal priority found at a
    // higher index replaces the earlier one, giving ties to the highest index.
    // The loop stops one short of the top index, which is reserved.
    always_comb begin
        bestFound = 1'b0;
        bestIdx   = '0;
        bestPrio  = '0;
        for (int i = 0; i < NrSrc - 1; i++) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > threshold_q)) begin
                if (!bestFound || (prio_q[i] >= bestPrio)) begin
                    bestFound = 1'b1;
                    bestIdx   = NR_INDEX_BITS'(i);
                    bestPrio  = prio_q[i];
                end
            end
        end
    end

    // Presentation is suppressed while the nesting stack is full so the core
    // can never be asked to push beyond the stack's capacity.
    always_comb begin
        stackFull    = (level_q == LevelW'(STACK_DEPTH));
        is_interrupt = bestFound && !stackFull;
        index        = is_interrupt ? bestIdx  : '0;
        prio         = is_interrupt ? bestPrio : '0;
        threshold    = threshold_q;
        level        = level_q;
    end

    // Next-state logic. Take wins over ret; a take without a presented
    // interrupt does nothing. New pend events are OR-ed in after the take
    // clears its source, so a fresh edge on the taken source stays pending.
    always_comb begin
        accept    = take && is_interrupt;
        popOk     = ret && !take && (level_q != '0);
        swMask    = sw_pend_we ? (NrSrc'(1) << sw_pend_idx) : '0;
        pendEvent = (irq_in & ~irqPrev_q) | swMask;

        prio_d      = prio_q;
        enable_d    = enable_q;
        pending_d   = pending_q;
        irqPrev_d   = irq_in;
        stack_d     = stack_q;
        threshold_d = threshold_q;
        level_d     = level_q;

        if (cfg_we) begin
            prio_d[cfg_idx]   = cfg_prio;
            enable_d[cfg_idx] = cfg_enable;
        end

        if (accept) begin
            pending_d[bestIdx] = 1'b0;
        end
        pending_d = pending_d | pendEvent;

        // The threshold copies the priority seen at take time, so later
        // reconfiguration of the running source leaves it untouched.
        if (accept) begin
            stack_d[0] = threshold_q;
            for (int k = 1; k < STACK_DEPTH; k++) begin
                stack_d[k] = stack_q[k-1];
            end
            threshold_d = bestPrio;
            level_d     = level_q + LevelW'(1);
        end else if (popOk) begin
            threshold_d = stack_q[0];
            for (int k = 0; k < STACK_DEPTH - 1; k++) begin
                stack_d[k] = stack_q[k+1];
            end
            stack_d[STACK_DEPTH-1] = '0;
            level_d = level_q - LevelW'(1);
        end
    end

    // State registers with synchronous reset that overrides every other
    // request, including in the middle of nested handlers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NrSrc; i++) begin
                prio_q[i] <= '0;
            end
            enable_q  <= '0;
            pending_q <= '0;
            irqPrev_q <= '0;
            for (int k = 0; k < STACK_DEPTH; k++) begin
                stack_q[k] <= '0;
            end
            threshold_q <= '0;
            level_q     <= '0;
        end else begin
            prio_q      <= prio_d;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            irqPrev_q   <= irqPrev_d;
            stack_q     <= stack_d;
            threshold_q <= threshold_d;
            level_q     <= level_d;
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the core handshake; they only warn because the
    // hardware tolerates both cases by ignoring the request.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(ret && !take && (level_q == '0)))
                else $warning("clic_preempt: ret with no active handler");
            assert (!(take && !is_interrupt))
                else $warning("clic_preempt: take with no presented interrupt");
        end
    end
`endif

endmodule

// File: tb/tb_clic_preempt.sv
// ---------------------------------------------------------------------------
// tb_clic_preempt
//
// Bench for clic_preempt. Two instances share all inputs: dutA with the
// default nesting depth of 4 and dutB with a nesting depth of 2. A
// behavioural model per instance (plain arrays and a stack) predicts the
// outputs, and a compare process checks both instances on every falling
// edge. Directed scenarios add literal expectations, followed by a long
// randomized phase.
// ---------------------------------------------------------------------------
module tb_clic_preempt;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [2:0]  cfg_prio;
    logic        cfg_enable;
    logic [15:0] irq_in;
    logic        sw_pend_we;
    logic [3:0]  sw_pend_idx;
    logic        take;
    logic        ret;

    logic        isIntA, isIntB;
    logic [3:0]  indexA, indexB;
    logic [2:0]  prioA, prioB;
    logic [2:0]  thrA, thrB;
    logic [2:0]  levelA;
    logic [1:0]  levelB;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 0;

    clic_preempt #(.NR_INDEX_BITS(4), .NR_PRIO_BITS(3), .STACK_DEPTH(4)) dutA (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_prio(cfg_prio), .cfg_enable(cfg_enable), .irq_in(irq_in),
        .sw_pend_we(sw_pend_we), .sw_pend_idx(sw_pend_idx), .take(take),
        .ret(ret), .is_interrupt(isIntA), .index(indexA), .prio(prioA),
        .threshold(thrA), .level(levelA)
    );

    clic_preempt #(.NR_INDEX_BITS(4), .NR_PRIO_BITS(3), .STACK_DEPTH(2)) dutB (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_prio(cfg_prio), .cfg_enable(cfg_enable), .irq_in(irq_in),
        .sw_pend_we(sw_pend_we), .sw_pend_idx(sw_pend_idx), .take(take),
        .ret(ret), .is_interrupt(isIntB), .index(indexB), .prio(prioB),
        .threshold(thrB), .level(levelB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state; index [m] selects the instance (0=A, 1=B)
    int mPrio [16];
    int mEn   [16];
    int mPrev [16];
    int mPend [2][16];
    int mStk  [2][16];
    int mThr  [2];
    int mLvl  [2];
    int mW;

    function automatic int depthOf(input int m);
        return (m == 0) ? 4 : 2;
    endfunction

    // Highest priority level first, then highest index inside that level;
    // index 15 is reserved and never considered.
    function automatic int winner(input int m);
        for (int p = 7; p > mThr[m]; p--) begin
            for (int i = 14; i >= 0; i--) begin
                if (mPend[m][i] != 0 && mEn[i] != 0 && mPrio[i] == p) return i;
            end
        end
        return -1;
    endfunction

    function automatic int expIsInt(input int m);
        return (winner(m) >= 0 && mLvl[m] < depthOf(m)) ? 1 : 0;
    endfunction

    // Model update on each rising edge, from the inputs and pre-edge state
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mPrio[i] = 0;
                mEn[i]   = 0;
                mPrev[i] = 0;
                mPend[0][i] = 0;
                mPend[1][i] = 0;
            end
            for (int m = 0; m < 2; m++) begin
                mThr[m] = 0;
                mLvl[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                mW = winner(m);
                if (take && mW >= 0 && mLvl[m] < depthOf(m)) begin
                    mStk[m][mLvl[m]] = mThr[m];
                    mThr[m] = mPrio[mW];
                    mLvl[m] = mLvl[m] + 1;
                    mPend[m][mW] = 0;
                end else if (ret && !take && mLvl[m] > 0) begin
                    mLvl[m] = mLvl[m] - 1;
                    mThr[m] = mStk[m][mLvl[m]];
                end
                for (int i = 0; i < 16; i++) begin
                    if ((irq_in[i] && mPrev[i] == 0) || (sw_pend_we && int'(sw_pend_idx) == i))
                        mPend[m][i] = 1;
                end
            end
            for (int i = 0; i < 16; i++) mPrev[i] = irq_in[i] ? 1 : 0;
            if (cfg_we) begin
                mPrio[cfg_idx] = int'(cfg_prio);
                mEn[cfg_idx]   = cfg_enable ? 1 : 0;
            end
        end
    end

    // One comparison with counting and a FAIL line on mismatch
    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input int m, input int isI, input int idx, input int pr,
                              input int thr, input int lvl);
        int e;
        int w;
        string tag;
        tag = (m == 0) ? "A" : "B";
        w = winner(m);
        e = expIsInt(m);
        checkOutput({tag, ".is_interrupt"}, isI, e);
        checkOutput({tag, ".index"}, idx, (e != 0) ? w : 0);
        checkOutput({tag, ".prio"}, pr, (e != 0) ? mPrio[w] : 0);
        checkOutput({tag, ".threshold"}, thr, mThr[m]);
        checkOutput({tag, ".level"}, lvl, mLvl[m]);
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (checkEn) begin
            compareDut(0, int'(isIntA), int'(indexA), int'(prioA), int'(thrA), int'(levelA));
            compareDut(1, int'(isIntB), int'(indexB), int'(prioB), int'(thrB), int'(levelB));
        end
    end

    // Advance one clock; outputs are settled on return and strobes cleared
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        cfg_we     = 1'b0;
        sw_pend_we = 1'b0;
        take       = 1'b0;
        ret        = 1'b0;
    endtask

    task automatic cfgSrc(input int idx, input int p, input int en);
        cfg_we     = 1'b1;
        cfg_idx    = 4'(idx);
        cfg_prio   = 3'(p);
        cfg_enable = (en != 0);
        applyStimulus();
    endtask

    task automatic swPend(input int idx);
        sw_pend_we  = 1'b1;
        sw_pend_idx = 4'(idx);
        applyStimulus();
    endtask

    task automatic doTake();
        take = 1'b1;
        applyStimulus();
    endtask

    task automatic doRet();
        ret = 1'b1;
        applyStimulus();
    endtask

    task automatic checkA(input string name, input int isI, input int idx, input int pr,
                          input int thr, input int lvl);
        checkOutput({name, " A.is_interrupt"}, int'(isIntA), isI);
        checkOutput({name, " A.index"}, int'(indexA), idx);
        checkOutput({name, " A.prio"}, int'(prioA), pr);
        checkOutput({name, " A.threshold"}, int'(thrA), thr);
        checkOutput({name, " A.level"}, int'(levelA), lvl);
    endtask

    task automatic checkB(input string name, input int isI, input int idx, input int pr,
                          input int thr, input int lvl);
        checkOutput({name, " B.is_interrupt"}, int'(isIntB), isI);
        checkOutput({name, " B.index"}, int'(indexB), idx);
        checkOutput({name, " B.prio"}, int'(prioB), pr);
        checkOutput({name, " B.threshold"}, int'(thrB), thr);
        checkOutput({name, " B.level"}, int'(levelB), lvl);
    endtask

    initial begin
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_prio    = '0;
        cfg_enable  = 1'b0;
        irq_in      = '0;
        sw_pend_we  = 1'b0;
        sw_pend_idx = '0;
        take        = 1'b0;
        ret         = 1'b0;

        applyStimulus();
        checkEn = 1;
        applyStimulus();
        reset = 1'b0;
        checkA("reset", 0, 0, 0, 0, 0);
        checkB("reset", 0, 0, 0, 0, 0);

        // Single source round trip
        cfgSrc(3, 2, 1);
        irq_in[3] = 1'b1;
        applyStimulus();
        checkA("single.pend", 1, 3, 2, 0, 0);
        doTake();
        checkA("single.take", 0, 0, 0, 2, 1);
        doRet();
        checkA("single.ret", 0, 0, 0, 0, 0);
        irq_in[3] = 1'b0;
        applyStimulus();

        // Tie goes to the higher index; reserved index never presented
        cfgSrc(5, 4, 1);
        cfgSrc(9, 4, 1);
        cfgSrc(15, 7, 1);
        irq_in[5]  = 1'b1;
        irq_in[9]  = 1'b1;
        irq_in[15] = 1'b1;
        applyStimulus();
        checkA("tie", 1, 9, 4, 0, 0);
        doTake();
        checkA("tie.take9", 0, 0, 0, 4, 1);
        doRet();
        checkA("tie.ret", 1, 5, 4, 0, 0);
        doTake();
        doRet();
        checkA("reserved", 0, 0, 0, 0, 0);
        irq_in = '0;
        applyStimulus();

        // Preemption by strictly higher priority only
        cfgSrc(2, 3, 1);
        cfgSrc(7, 3, 1);
        cfgSrc(1, 5, 1);
        swPend(2);
        checkA("pre.src2", 1, 2, 3, 0, 0);
        doTake();
        checkA("pre.take2", 0, 0, 0, 3, 1);
        swPend(7);
        checkA("pre.samePrio", 0, 0, 0, 3, 1);
        swPend(1);
        checkA("pre.src1", 1, 1, 5, 3, 1);
        doTake();
        checkA("pre.take1", 0, 0, 0, 5, 2);
        doRet();
        checkA("pre.ret1", 0, 0, 0, 3, 1);
        doRet();
        checkA("pre.ret2", 1, 7, 3, 0, 0);
        doTake();
        doRet();

        // Stack full on the depth-2 instance
        cfgSrc(10, 1, 1);
        cfgSrc(11, 2, 1);
        cfgSrc(12, 6, 1);
        swPend(10);
        doTake();
        swPend(11);
        doTake();
        checkB("full.nest", 0, 0, 0, 2, 2);
        swPend(12);
        checkB("full.pend", 0, 0, 0, 2, 2);
        checkA("full.pendA", 1, 12, 6, 2, 2);
        applyStimulus();
        applyStimulus();
        checkB("full.hold", 0, 0, 0, 2, 2);
        doRet();
        checkB("full.ret", 1, 12, 6, 1, 1);
        doTake();
        checkB("full.take", 0, 0, 0, 6, 2);
        doRet();
        doRet();
        checkB("full.unwind", 0, 0, 0, 0, 0);

        // Take and new rise on the same source at the same edge
        cfgSrc(6, 5, 1);
        irq_in[6] = 1'b1;
        applyStimulus();
        checkA("same.pend", 1, 6, 5, 0, 0);
        irq_in[6] = 1'b0;
        applyStimulus();
        irq_in[6] = 1'b1;
        take = 1'b1;
        applyStimulus();
        checkA("same.take", 0, 0, 0, 5, 1);
        doRet();
        checkA("same.stillPending", 1, 6, 5, 0, 0);
        doTake();
        doRet();
        irq_in[6] = 1'b0;
        applyStimulus();
        doRet();
        checkA("retAtZero", 0, 0, 0, 0, 0);

        // Reset in the middle of three nested handlers
        cfgSrc(8, 1, 1);
        cfgSrc(13, 2, 1);
        cfgSrc(14, 3, 1);
        swPend(8);
        doTake();
        swPend(13);
        doTake();
        swPend(14);
        doTake();
        checkA("deep.nest", 0, 0, 0, 3, 3);
        swPend(0);
        reset      = 1'b1;
        cfg_we     = 1'b1;
        cfg_idx    = 4'd4;
        cfg_prio   = 3'd7;
        cfg_enable = 1'b1;
        sw_pend_we = 1'b1;
        sw_pend_idx = 4'd4;
        ret        = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkA("midReset", 0, 0, 0, 0, 0);
        checkB("midReset", 0, 0, 0, 0, 0);

        // Held irq produces a single pend event
        cfgSrc(4, 3, 1);
        irq_in[4] = 1'b1;
        applyStimulus();
        checkA("held.first", 1, 4, 3, 0, 0);
        doTake();
        doRet();
        for (int c = 0; c < 7; c++) begin
            applyStimulus();
            checkA("held.once", 0, 0, 0, 0, 0);
        end
        irq_in[4] = 1'b0;
        applyStimulus();

        // Randomized phase against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(2) == 0) begin
                int k;
                k = $urandom_range(15);
                irq_in[k] = ~irq_in[k];
            end
            if ($urandom_range(7) == 0) begin
                cfg_we     = 1'b1;
                cfg_idx    = 4'($urandom_range(15));
                cfg_prio   = 3'($urandom_range(7));
                cfg_enable = ($urandom_range(3) != 0);
            end
            if ($urandom_range(5) == 0) begin
                sw_pend_we  = 1'b1;
                sw_pend_idx = 4'($urandom_range(15));
            end
            take = (expIsInt(0) != 0) && (expIsInt(1) != 0) && ($urandom_range(2) == 0);
            ret  = (mLvl[0] > 0) && (mLvl[1] > 0) && ($urandom_range(4) == 0);
            reset = ($urandom_range(399) == 0);
            applyStimulus();
            reset = 1'b0;
        end

        applyStimulus();
        checkEn = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
